seq_sync: RTL and testbench

Frame-sync detector that sits directly downstream of the seq_enc state-machine encoder and consumes its serial output, sm_out, one bit per clock.
- Searches the bit stream for a fixed sync pattern.
- Verifies that the pattern repeats at a fixed frame period, then declares lock.
- After lock, tracks the pattern and drops lock after consecutive misses.
- Provides raw match pulses, frame-start pulses, a lock flag and a saturating match counter for downstream framing logic.

---
 rtl/seq_pkg.sv | 37 +++
 rtl/seq_sync_if.sv | 40 ++++
 rtl/seq_shift_cmp.sv | 61 ++++++
 rtl/seq_sync.sv | 171 +++++++++++++++++
 tb/tb_seq_sync.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// -----------------------------------------------------------------------------
// seq_pkg
// Shared types and sizing helpers for the seq_sync frame-sync detector.
//   state_t   : FSM state encoding (SEARCH, VERIFY, LOCKED), 2 bits
//   cnt_width : number of bits needed to hold values 0..n-1, never below 1
//   POS_W / HITS_W / MISS_W : counter widths for the default PERIOD,
//                             LOCK_N and LOSS_N
// -----------------------------------------------------------------------------
package seq_pkg;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // A counter that only ever holds 0..n-1 needs clog2(n) bits. A zero-width
    // vector is illegal, so the result is clamped to one bit.
    function automatic int cnt_width(input int n);
        int w;
        if (n <= 1) begin
            w = 1;
        end else begin
            w = $clog2(n);
        end
        return w;
    endfunction

    localparam int DEF_PERIOD = 8;
    localparam int DEF_LOCK_N = 3;
    localparam int DEF_LOSS_N = 2;

    localparam int POS_W  = cnt_width(DEF_PERIOD);
    localparam int HITS_W = cnt_width(DEF_LOCK_N);
    localparam int MISS_W = cnt_width(DEF_LOSS_N);

endpackage

// File: rtl/seq_sync_if.sv
// -----------------------------------------------------------------------------
// seq_sync_if
// Bit-stream input and framing outputs of the seq_sync detector.
//   en          : bit strobe, bit_in is valid only when en = 1
//   bit_in      : serial data (seq_enc sm_out)
//   match       : one-cycle pulse on any pattern hit
//   frame_start : one-cycle pulse on each in-phase hit while locked
//   locked      : high while the detector is locked
//   match_cnt   : saturating count of match pulses
// Modports: master drives the stream and observes results, slave is the
// detector.
// -----------------------------------------------------------------------------
interface seq_sync_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             bit_in;
    logic             match;
    logic             frame_start;
    logic             locked;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en,
        output bit_in,
        input  match,
        input  frame_start,
        input  locked,
        input  match_cnt
    );

    modport slave (
        input  en,
        input  bit_in,
        output match,
        output frame_start,
        output locked,
        output match_cnt
    );
endinterface

// File: rtl/seq_shift_cmp.sv
// -----------------------------------------------------------------------------
// seq_shift_cmp
// Shift register, fill counter and pattern comparator for seq_sync.
//   clk, reset : clock and synchronous active-high reset
//   en         : bit strobe
//   bit_in     : serial data
//   hit        : combinational; high when the bit sampled on this edge
//                completes PATTERN and at least PAT_W bits have been
//                received since reset
// -----------------------------------------------------------------------------
module seq_shift_cmp #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic bit_in,
    output logic hit
);

    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  sr_r;
    logic [FILL_W-1:0] fill_r;
    logic [PAT_W-1:0]  sr_next_s;
    logic [FILL_W-1:0] fill_next_s;

    // Next shift-register/fill values and the hit decision on the incoming bit.
    always_comb begin
        sr_next_s   = {sr_r[PAT_W-2:0], bit_in};
        fill_next_s = fill_r;
        hit         = 1'b0;
        if (fill_r == FILL_W'(PAT_W)) begin
            fill_next_s = fill_r;
        end else begin
            fill_next_s = fill_r + FILL_W'(1);
        end
        // fill guards against a match built from post-reset zeros.
        if (en && (sr_next_s == PATTERN) && (fill_next_s == FILL_W'(PAT_W))) begin
            hit = 1'b1;
        end else begin
            hit = 1'b0;
        end
    end

    // Shift register and fill counter advance only on strobed edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_r   <= {PAT_W{1'b0}};
            fill_r <= {FILL_W{1'b0}};
        end else if (en) begin
            sr_r   <= sr_next_s;
            fill_r <= fill_next_s;
        end else begin
            sr_r   <= sr_r;
            fill_r <= fill_r;
        end
    end

endmodule

// File: rtl/seq_sync.sv
// -----------------------------------------------------------------------------
// seq_sync
// Frame-sync detector for the seq_enc serial stream. Searches for PATTERN,
// verifies that it repeats every PERIOD bits LOCK_N times, then locks and
// tracks it, dropping lock after LOSS_N consecutive in-phase misses.
//   clk   : system clock, rising edge
//   reset : synchronous active-high reset
//   bus   : seq_sync_if slave (en, bit_in in; match, frame_start, locked,
//           match_cnt out, all registered)
// -----------------------------------------------------------------------------
module seq_sync
    import seq_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               PERIOD  = 8,
    parameter int               LOCK_N  = 3,
    parameter int               LOSS_N  = 2,
    parameter int               CNT_W   = 8
) (
    input  logic        clk,
    input  logic        reset,
    seq_sync_if.slave   bus
);

    localparam int POS_BITS  = cnt_width(PERIOD);
    localparam int HIT_BITS  = cnt_width(LOCK_N);
    localparam int MISS_BITS = cnt_width(LOSS_N);

    state_t               state_r;
    state_t               state_n;
    logic [POS_BITS-1:0]  pos_r;
    logic [POS_BITS-1:0]  pos_n;
    logic [HIT_BITS-1:0]  hits_r;
    logic [HIT_BITS-1:0]  hits_n;
    logic [MISS_BITS-1:0] misses_r;
    logic [MISS_BITS-1:0] misses_n;
    logic                 match_r;
    logic                 match_n;
    logic                 frame_start_r;
    logic                 frame_start_n;
    logic                 locked_r;
    logic                 locked_n;
    logic [CNT_W-1:0]     match_cnt_r;
    logic [CNT_W-1:0]     match_cnt_n;
    logic                 hit_s;
    logic                 check_pt_s;

    seq_shift_cmp #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_shift_cmp (
        .clk    (clk),
        .reset  (reset),
        .en     (bus.en),
        .bit_in (bus.bit_in),
        .hit    (hit_s)
    );

    // Next-state, counter and output decode; nothing moves on en=0 edges.
    always_comb begin
        state_n       = state_r;
        pos_n         = pos_r;
        hits_n        = hits_r;
        misses_n      = misses_r;
        match_n       = 1'b0;
        frame_start_n = 1'b0;
        match_cnt_n   = match_cnt_r;
        check_pt_s    = (pos_r == POS_BITS'(PERIOD - 1));

        if (bus.en) begin
            match_n = hit_s;
            case (state_r)
                SEARCH: begin
                    // Every sampled bit is a candidate, so hits may overlap.
                    if (hit_s) begin
                        state_n = VERIFY;
                        hits_n  = HIT_BITS'(1);
                        pos_n   = {POS_BITS{1'b0}};
                    end else begin
                        pos_n   = pos_r;
                    end
                end
                VERIFY: begin
                    // Off-phase hits only pulse match; the anchor stays put.
                    if (check_pt_s) begin
                        pos_n = {POS_BITS{1'b0}};
                        if (hit_s) begin
                            if ((int'(hits_r) + 1) == LOCK_N) begin
                                state_n       = LOCKED;
                                misses_n      = {MISS_BITS{1'b0}};
                                frame_start_n = 1'b1;
                            end else begin
                                hits_n = hits_r + HIT_BITS'(1);
                            end
                        end else begin
                            // The failing bit is not re-tried as a new anchor.
                            state_n = SEARCH;
                            hits_n  = {HIT_BITS{1'b0}};
                        end
                    end else begin
                        pos_n = pos_r + POS_BITS'(1);
                    end
                end
                LOCKED: begin
                    // pos wraps at every check point so phase is never lost.
                    if (check_pt_s) begin
                        pos_n = {POS_BITS{1'b0}};
                        if (hit_s) begin
                            misses_n      = {MISS_BITS{1'b0}};
                            frame_start_n = 1'b1;
                        end else if ((int'(misses_r) + 1) == LOSS_N) begin
                            state_n  = SEARCH;
                            misses_n = {MISS_BITS{1'b0}};
                            hits_n   = {HIT_BITS{1'b0}};
                        end else begin
                            misses_n = misses_r + MISS_BITS'(1);
                        end
                    end else begin
                        pos_n = pos_r + POS_BITS'(1);
                    end
                end
                default: begin
                    state_n  = SEARCH;
                    pos_n    = {POS_BITS{1'b0}};
                    hits_n   = {HIT_BITS{1'b0}};
                    misses_n = {MISS_BITS{1'b0}};
                end
            endcase
        end else begin
            match_n = 1'b0;
        end

        locked_n = (state_n == LOCKED);

        if (match_n && (match_cnt_r != {CNT_W{1'b1}})) begin
            match_cnt_n = match_cnt_r + CNT_W'(1);
        end else begin
            match_cnt_n = match_cnt_r;
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= SEARCH;
            pos_r         <= {POS_BITS{1'b0}};
            hits_r        <= {HIT_BITS{1'b0}};
            misses_r      <= {MISS_BITS{1'b0}};
            match_r       <= 1'b0;
            frame_start_r <= 1'b0;
            locked_r      <= 1'b0;
            match_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            state_r       <= state_n;
            pos_r         <= pos_n;
            hits_r        <= hits_n;
            misses_r      <= misses_n;
            match_r       <= match_n;
            frame_start_r <= frame_start_n;
            locked_r      <= locked_n;
            match_cnt_r   <= match_cnt_n;
        end
    end

    assign bus.match       = match_r;
    assign bus.frame_start = frame_start_r;
    assign bus.locked      = locked_r;
    assign bus.match_cnt   = match_cnt_r;

endmodule

// File: tb/tb_seq_sync.sv
// -----------------------------------------------------------------------------
// tb_seq_sync
// Scoreboard bench for seq_sync. Two instances share one stream: CNT_W=8 and
// CNT_W=2 (saturation). The stimulus process runs a behavioural model per
// clock and queues the expected outputs; a monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_seq_sync;

    localparam int         PAT_W   = 4;
    localparam int         PATTERN = 11;   // 4'b1011
    localparam int         PERIOD  = 8;
    localparam int         LOCK_N  = 3;
    localparam int         LOSS_N  = 2;
    localparam int         CNT_MAX = 255;
    localparam int         CNT2_MAX = 3;

    typedef struct {
        logic m;
        logic fs;
        logic lk;
        int   cnt;
    } exp_t;

    logic clk;
    logic reset;
    logic en;
    logic bit_in;

    int n_cmp;
    int n_bad;
    int cycle;

    exp_t exp_q[$];

    // model state (written only by the stimulus process)
    int m_nbits;
    int m_win;
    int m_mode;   // 0 search, 1 verify, 2 locked
    int m_anchor;
    int m_ecnt;
    int m_hits;
    int m_miss;
    int m_cnt;

    logic [7:0] good_fr;
    logic [7:0] bad_fr;

    seq_sync_if #(.CNT_W(8)) ifa ();
    seq_sync_if #(.CNT_W(2)) ifb ();

    assign ifa.en     = en;
    assign ifa.bit_in = bit_in;
    assign ifb.en     = en;
    assign ifb.bit_in = bit_in;

    seq_sync #(.CNT_W(8)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    seq_sync #(.CNT_W(2)) u_dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: hit = last PAT_W bits since reset equal PATTERN; check
    // points are en edges a whole number of periods after the anchor hit.
    task automatic model_step(input logic r, input logic e, input logic b);
        exp_t x;
        bit   hit;
        bit   fs;
        bit   at;
        hit = 1'b0;
        fs  = 1'b0;
        if (r) begin
            m_nbits = 0; m_win = 0; m_mode = 0; m_anchor = 0;
            m_ecnt = 0; m_hits = 0; m_miss = 0; m_cnt = 0;
        end else if (e) begin
            m_ecnt  = m_ecnt + 1;
            m_nbits = m_nbits + 1;
            m_win   = ((m_win << 1) | int'(b)) & ((1 << PAT_W) - 1);
            hit     = (m_nbits >= PAT_W) && (m_win == PATTERN);
            at      = ((m_ecnt - m_anchor) % PERIOD) == 0;
            if (m_mode == 0) begin
                if (hit) begin
                    m_mode = 1; m_anchor = m_ecnt; m_hits = 1;
                end
            end else if (m_mode == 1) begin
                if (at) begin
                    if (hit) begin
                        m_hits = m_hits + 1;
                        if (m_hits == LOCK_N) begin
                            m_mode = 2; m_miss = 0; fs = 1'b1;
                        end
                    end else begin
                        m_mode = 0; m_hits = 0;
                    end
                end
            end else begin
                if (at) begin
                    if (hit) begin
                        m_miss = 0; fs = 1'b1;
                    end else begin
                        m_miss = m_miss + 1;
                        if (m_miss == LOSS_N) begin
                            m_mode = 0; m_miss = 0; m_hits = 0;
                        end
                    end
                end
            end
            if (hit && m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end
        x.m   = hit;
        x.fs  = fs;
        x.lk  = (m_mode == 2);
        x.cnt = m_cnt;
        exp_q.push_back(x);
    endtask

    task automatic send(input logic r, input logic e, input logic b);
        @(negedge clk);
        reset  = r;
        en     = e;
        bit_in = b;
        model_step(r, e, b);
    endtask

    task automatic send_frame(input logic [7:0] f, input bit tog);
        for (int i = 7; i >= 0; i--) begin
            if (tog) send(1'b0, 1'b0, 1'($urandom_range(1, 0)));
            send(1'b0, 1'b1, f[i]);
        end
    endtask

    task automatic dcheck(input string name, input int act, input int want);
        n_cmp++;
        if (act != want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cycle);
        end
    endtask

    // Monitor: one expected entry per clock, compared #1 after the edge.
    initial begin
        exp_t x;
        int   c2;
        cycle = 0;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                x  = exp_q.pop_front();
                c2 = (x.cnt > CNT2_MAX) ? CNT2_MAX : x.cnt;
                n_cmp++;
                if (ifa.match !== x.m || ifa.frame_start !== x.fs ||
                    ifa.locked !== x.lk || int'(ifa.match_cnt) != x.cnt ||
                    $isunknown(ifa.match_cnt)) begin
                    n_bad++;
                    $display("FAIL dut8 cycle %0d: got m=%0b fs=%0b lk=%0b cnt=%0d, expected m=%0b fs=%0b lk=%0b cnt=%0d",
                             cycle, ifa.match, ifa.frame_start, ifa.locked, ifa.match_cnt,
                             x.m, x.fs, x.lk, x.cnt);
                end
                n_cmp++;
                if (ifb.match !== x.m || ifb.frame_start !== x.fs ||
                    ifb.locked !== x.lk || int'(ifb.match_cnt) != c2 ||
                    $isunknown(ifb.match_cnt)) begin
                    n_bad++;
                    $display("FAIL dut2 cycle %0d: got m=%0b fs=%0b lk=%0b cnt=%0d, expected m=%0b fs=%0b lk=%0b cnt=%0d",
                             cycle, ifb.match, ifb.frame_start, ifb.locked, ifb.match_cnt,
                             x.m, x.fs, x.lk, c2);
                end
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "timeout");
    end

    initial begin
        int idx;
        logic b;
        n_cmp   = 0;
        n_bad   = 0;
        good_fr = 8'b1011_0000;
        bad_fr  = 8'b1001_0000;
        reset   = 1'b1;
        en      = 1'b0;
        bit_in  = 1'b0;
        model_step(1'b1, 1'b0, 1'b0);

        // 1: reset then frames; lock on bit 19, both counters at 3
        send(1'b1, 1'b0, 1'b0);
        send(1'b1, 1'b0, 1'b0);
        send_frame(good_fr, 1'b0);
        send_frame(good_fr, 1'b0);
        for (int i = 7; i >= 4; i--) send(1'b0, 1'b1, good_fr[i]);
        @(posedge clk); #1;
        dcheck("locked_at_bit19", int'(ifa.locked), 1);
        dcheck("frame_start_at_bit19", int'(ifa.frame_start), 1);
        dcheck("cnt_at_bit19", int'(ifa.match_cnt), 3);
        for (int i = 3; i >= 0; i--) send(1'b0, 1'b1, good_fr[i]);
        send_frame(good_fr, 1'b0);
        send_frame(good_fr, 1'b0);
        dcheck("cnt2_saturated", int'(ifb.match_cnt), 3);

        // 2: one corrupt frame keeps lock, two consecutive drop it
        send_frame(bad_fr, 1'b0);
        dcheck("lock_kept_one_miss", int'(ifa.locked), 1);
        send_frame(good_fr, 1'b0);
        send_frame(bad_fr, 1'b0);
        send_frame(bad_fr, 1'b0);
        for (int k = 0; k < 4; k++) send_frame(good_fr, 1'b0);

        // 3: overlapping 1011_1011 then silence
        send(1'b1, 1'b0, 1'b0);
        send_frame(8'b1011_1011, 1'b0);
        send_frame(8'b0000_0000, 1'b0);
        send_frame(8'b0000_0000, 1'b0);
        dcheck("overlap_no_lock", int'(ifa.locked), 0);
        dcheck("overlap_cnt", int'(ifa.match_cnt), 2);

        // 4: en toggling every cycle
        send(1'b1, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) send_frame(good_fr, 1'b1);
        dcheck("lock_with_en_toggle", int'(ifa.locked), 1);

        // 5: reset at bit 17 of a fresh run, then relock from scratch
        send(1'b1, 1'b0, 1'b0);
        send_frame(good_fr, 1'b0);
        send_frame(good_fr, 1'b0);
        send(1'b0, 1'b1, good_fr[7]);
        send(1'b1, 1'b1, good_fr[6]);
        @(posedge clk); #1;
        dcheck("reset_clears_cnt", int'(ifa.match_cnt), 0);
        dcheck("reset_clears_locked", int'(ifa.locked), 0);
        for (int k = 0; k < 4; k++) send_frame(good_fr, 1'b0);

        // random: framed stream with bit errors, gaps and rare resets
        idx = 0;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(199, 0) == 0) begin
                send(1'b1, 1'b0, 1'b0);
            end else if ($urandom_range(3, 0) == 0) begin
                send(1'b0, 1'b0, 1'($urandom_range(1, 0)));
            end else begin
                b = good_fr[7 - idx];
                if ($urandom_range(24, 0) == 0) b = ~b;
                send(1'b0, 1'b1, b);
                idx = (idx + 1) % 8;
            end
        end

        send(1'b0, 1'b0, 1'b0);
        @(posedge clk); #2;
        dcheck("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
